// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Boot-load stream between a program loader and instr_fetch_unit.
//   The loader pulses start_load to begin a (re)load from address 0. It then
//   streams words with a valid/ready handshake. ld_last marks the final word.
//
//   Signals
//     start_load  loader -> unit  1-cycle pulse, begin (re)loading at address 0
//     ld_valid    loader -> unit  ld_data holds a word
//     ld_data     loader -> unit  program word (DATA_W bits)
//     ld_last     loader -> unit  qualifies the final word of the program
//     ld_ready    unit -> loader  unit accepts a word this cycle
//
//   Modports
//     master  loader side
//     slave   fetch-unit side
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int DATA_W = 16
) ();

  logic              start_load;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  modport master (
    output start_load, ld_valid, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  start_load, ld_valid, ld_data, ld_last,
    output ld_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Program store and fetch stage that sits in front of the processor core.
//   A program is boot-loaded over the ld stream into a DEPTH x DATA_W RAM.
//   The unit then serves one registered instruction per cycle, addressed by
//   the core's pc. It stops issuing once a HALT_WORD has been issued.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-low reset
//     ld           load stream (start_load, ld_valid/ld_data/ld_last, ld_ready)
//     pc           fetch address from the core
//     Instruction  registered instruction to the core (1-cycle latency from pc)
//     instr_valid  Instruction holds a program word fetched while running
//     cpu_run      core enable; high only while running
//     prog_len     number of words written by the last load (0..DEPTH)
//     load_err     sticky: the last load filled the RAM without seeing ld_last
//     halted       HALT_WORD has been issued and the unit has stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hF000
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.slave  ld,
  input  logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  Instruction,
  output logic               instr_valid,
  output logic               cpu_run,
  output logic [ADDR_W:0]    prog_len,
  output logic               load_err,
  output logic               halted
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;

  logic restart;     // start_load wins over everything else in the same cycle
  logic accept;      // a load word is written this cycle
  logic last_slot;   // the write pointer addresses the final RAM word
  logic pc_in_prog;  // pc lies inside the loaded program
  logic fetch;       // the instruction register captures a RAM word this edge
  logic halt_seen;   // the word now on Instruction is the halt marker

  // Status outputs are straight decodes of the state register. They therefore
  // drop to their reset values as soon as reset is asserted.
  assign ld.ld_ready = (state == LOAD);
  assign cpu_run     = (state == RUN);
  assign halted      = (state == HALT);

  assign restart    = ld.start_load;
  // A word offered in the same cycle as start_load is dropped. The restart
  // rewinds the write pointer instead.
  assign accept     = ld.ld_valid && ld.ld_ready && !restart;
  assign last_slot  = &wptr;
  // prog_len is one bit wider than pc. A full RAM therefore never aliases to 0.
  assign pc_in_prog = ({1'b0, pc} < prog_len);
  assign halt_seen  = instr_valid && (Instruction == HALT_WORD);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first. If any path leaves a variable unassigned, a latch is inferred.
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        // LOAD is left only on an accepted word: a zero-length program is not possible.
        LOAD: if (accept && (ld.ld_last || last_slot)) state_next = RUN;
        RUN:  if (halt_seen) state_next = HALT;
        HALT: state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Fetch only while the unit stays in RUN. Any edge that leaves RUN, whether
  // for a halt or an abort by start_load, parks Instruction on NOP_WORD.
  assign fetch = (state == RUN) && (state_next == RUN);

  // NOTE: sequential blocks use non-blocking '<=' so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Load bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      prog_len <= '0;
      load_err <= 1'b0;
    end else if (restart) begin
      wptr     <= '0;
      prog_len <= '0;
      load_err <= 1'b0;
    end else if (accept) begin
      wptr     <= wptr + 1'b1;
      prog_len <= prog_len + 1'b1;
      // The RAM filled before the loader marked its final word.
      if (last_slot && !ld.ld_last) begin
        load_err <= 1'b1;
      end
    end
  end

  // NOTE: the program RAM has no reset. A reset clears prog_len, so stale
  // contents are never issued. Leaving the array unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= ld.ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction register: registered RAM read, one cycle behind pc
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruction <= NOP_WORD;
      instr_valid <= 1'b0;
    end else if (fetch && pc_in_prog) begin
      Instruction <= mem[pc];
      instr_valid <= 1'b1;
    end else begin
      Instruction <= NOP_WORD;
      instr_valid <= 1'b0;
    end
  end

endmodule
